// File: rtl/text_console_writer.sv
// Character-stream front end for the VGA text buffer.
// Takes one byte per handshake, turns printable bytes into glyph writes at the
// cursor, interprets backspace/CR/LF/FF, and scrolls or wraps at end of screen.
// Every RAM-facing output is registered, so a write is presented on the cycle
// after the byte (or scroll step) that caused it.
module text_console_writer #(
    parameter int          COLS         = 40,
    parameter int          ROWS         = 16,
    parameter int          COL_BITS     = 6,
    parameter int          ROW_BITS     = 4,
    parameter logic [7:0]  GLYPH_OFFSET = 8'h20,
    parameter logic [7:0]  BS_CODE      = 8'h60,
    parameter int          SCROLL_EN    = 1,
    localparam int         ADDR_W       = ROW_BITS + COL_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                char_valid,
    input  logic [7:0]          char_data,
    output logic                char_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [7:0]          wr_data,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [7:0]          rd_data,
    output logic [ROW_BITS-1:0] cur_row,
    output logic [COL_BITS-1:0] cur_col,
    output logic                busy
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
    // Last source row of the scroll copy is ROWS-1; the last destination is ROWS-2.
    localparam logic [ROW_BITS-1:0] PEN_ROW  = ROW_BITS'((ROWS > 1) ? ROWS - 2 : 0);

    typedef enum logic [2:0] {IDLE, SCR_RD, SCR_WR, SCR_CLR, CLEAR} state_t;

    state_t                state, state_n;
    logic [ROW_BITS-1:0]   row_q, row_n;
    logic [COL_BITS-1:0]   col_q, col_n;
    logic [ROW_BITS-1:0]   scr_row_q, scr_row_n;
    logic [COL_BITS-1:0]   scr_col_q, scr_col_n;
    logic                  wr_en_q, wr_en_n;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_n;
    logic [7:0]            wr_data_q, wr_data_n;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_n;
    logic                  newline;
    logic                  is_bs;

    // Glyph index is the byte offset into the font, modulo 256.
    function automatic logic [7:0] glyph_of(input logic [7:0] b);
        return b - GLYPH_OFFSET;
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E) && (b != BS_CODE);
    endfunction

    // State, cursor, sweep counters and registered RAM-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            scr_row_q <= '0;
            scr_col_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state     <= state_n;
            row_q     <= row_n;
            col_q     <= col_n;
            scr_row_q <= scr_row_n;
            scr_col_q <= scr_col_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            rd_addr_q <= rd_addr_n;
        end
    end

    // Next-state, cursor movement and the next RAM access.
    always_comb begin
        state_n   = state;
        row_n     = row_q;
        col_n     = col_q;
        scr_row_n = scr_row_q;
        scr_col_n = scr_col_q;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        rd_addr_n = rd_addr_q;
        newline   = 1'b0;
        is_bs     = (char_data == BS_CODE) || (char_data == 8'h08);

        case (state)
            IDLE: begin
                if (char_valid) begin
                    if (is_bs) begin
                        if (col_q != '0) begin
                            col_n     = col_q - 1'b1;
                            wr_en_n   = 1'b1;
                            wr_addr_n = {row_q, col_q - 1'b1};
                            wr_data_n = 8'h00;
                        end else if (row_q != '0) begin
                            row_n     = row_q - 1'b1;
                            col_n     = LAST_COL;
                            wr_en_n   = 1'b1;
                            wr_addr_n = {row_q - 1'b1, LAST_COL};
                            wr_data_n = 8'h00;
                        end
                    end else if (is_printable(char_data)) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = {row_q, col_q};
                        wr_data_n = glyph_of(char_data);
                        if (col_q != LAST_COL) col_n = col_q + 1'b1;
                        else                   newline = 1'b1;
                    end else if (char_data == 8'h0D) begin
                        col_n = '0;
                    end else if (char_data == 8'h0A) begin
                        newline = 1'b1;
                    end else if (char_data == 8'h0C) begin
                        state_n   = CLEAR;
                        scr_row_n = '0;
                        scr_col_n = '0;
                    end

                    if (newline) begin
                        col_n = '0;
                        if (row_q != LAST_ROW) begin
                            row_n = row_q + 1'b1;
                        end else if (SCROLL_EN != 0) begin
                            // Cursor parks on the bottom row; the copy starts at row 0.
                            row_n     = LAST_ROW;
                            state_n   = (ROWS > 1) ? SCR_RD : SCR_CLR;
                            scr_row_n = '0;
                            scr_col_n = '0;
                            rd_addr_n = {ROW_BITS'(1), COL_BITS'(0)};
                        end else begin
                            row_n = '0;
                        end
                    end
                end
            end

            // rd_addr is already on the bus; the RAM answers next cycle.
            SCR_RD: state_n = SCR_WR;

            SCR_WR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {scr_row_q, scr_col_q};
                wr_data_n = rd_data;
                if (scr_col_q != LAST_COL) begin
                    scr_col_n = scr_col_q + 1'b1;
                    rd_addr_n = {scr_row_q + 1'b1, scr_col_q + 1'b1};
                    state_n   = SCR_RD;
                end else if (scr_row_q != PEN_ROW) begin
                    scr_col_n = '0;
                    scr_row_n = scr_row_q + 1'b1;
                    rd_addr_n = {scr_row_q + 2'd2, COL_BITS'(0)};
                    state_n   = SCR_RD;
                end else begin
                    scr_col_n = '0;
                    state_n   = SCR_CLR;
                end
            end

            SCR_CLR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {LAST_ROW, scr_col_q};
                wr_data_n = 8'h00;
                if (scr_col_q != LAST_COL) begin
                    scr_col_n = scr_col_q + 1'b1;
                end else begin
                    scr_col_n = '0;
                    state_n   = IDLE;
                end
            end

            CLEAR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {scr_row_q, scr_col_q};
                wr_data_n = 8'h00;
                if (scr_col_q != LAST_COL) begin
                    scr_col_n = scr_col_q + 1'b1;
                end else begin
                    scr_col_n = '0;
                    if (scr_row_q != LAST_ROW) begin
                        scr_row_n = scr_row_q + 1'b1;
                    end else begin
                        scr_row_n = '0;
                        row_n     = '0;
                        col_n     = '0;
                        state_n   = IDLE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign char_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rd_addr    = rd_addr_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: default geometry with scrolling, plus a
// second instance with SCROLL_EN=0 fed the same byte stream.
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        char_valid;
    logic [7:0]  char_data;

    logic        char_ready, wr_en, busy;
    logic [9:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data;
    logic [3:0]  cur_row;
    logic [5:0]  cur_col;

    logic        char_ready2, wr_en2, busy2;
    logic [9:0]  wr_addr2, rd_addr2;
    logic [7:0]  wr_data2, rd_data2;
    logic [3:0]  cur_row2;
    logic [5:0]  cur_col2;

    always #5 clk = ~clk;

    text_console_writer dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .cur_row(cur_row), .cur_col(cur_col),
        .busy(busy)
    );

    text_console_writer #(.SCROLL_EN(0)) dut_wrap (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .cur_row(cur_row2), .cur_col(cur_col2),
        .busy(busy2)
    );

    // Character RAMs with one-cycle read latency.
    logic [7:0] mem   [0:1023];
    logic [7:0] mem2  [0:1023];
    logic [7:0] model [0:1023];

    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
        if (wr_en2) mem2[wr_addr2] <= wr_data2;
        rd_data2 <= mem2[rd_addr2];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected writes {addr, data}, in order.
    logic [17:0] exp_q [$];
    logic [17:0] exp_e;
    bit          sb_en = 1'b1;

    function automatic logic [9:0] A(input int r, input int c);
        return 10'(r * 64 + c);
    endfunction

    function automatic void expect_wr(input logic [9:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        model[a] = d;
    endfunction

    always @(negedge clk) begin
        if (sb_en && !reset && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         wr_addr, wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                chk("write", {14'd0, wr_addr, wr_data}, {14'd0, exp_e});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: char_ready still 0 after %0d cycles, expected 1", n);
        end
        char_valid = 1'b1;
        char_data  = b;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic chk_cur(input string name, input int r, input int c);
        chk(name, {22'd0, cur_row, cur_col}, {22'd0, 4'(r), 6'(c)});
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [7:0] b;

        char_valid = 1'b0;
        char_data  = 8'h00;
        reset      = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            mem[i]   = 8'h00;
            mem2[i]  = 8'h00;
            model[i] = 8'h00;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_en", {31'd0, wr_en}, 0);
        chk("reset_wr_addr", {22'd0, wr_addr}, 0);
        chk("reset_wr_data", {24'd0, wr_data}, 0);
        chk("reset_rd_addr", {22'd0, rd_addr}, 0);
        chk_cur("reset_cursor", 0, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, char_ready}, 1);

        // Basic printable, CR, line fill and wrap to next row.
        expect_wr(A(0, 0), 8'h21); send(8'h41); chk_cur("after_A", 0, 1);
        send(8'h0D); chk_cur("after_CR", 0, 0);
        for (int i = 0; i < 40; i++) begin
            expect_wr(A(0, i), 8'h22);
            send(8'h42);
        end
        chk_cur("after_40B", 1, 0);
        expect_wr(A(1, 0), 8'h23); send(8'h43); chk_cur("after_C", 1, 1);

        // Backspace in-row, across rows, and at origin.
        expect_wr(A(1, 0), 8'h00); send(8'h08); chk_cur("bs08", 1, 0);
        expect_wr(A(0, 39), 8'h00); send(8'h60); chk_cur("bs60_wrap", 0, 39);
        send(8'h0D); chk_cur("cr", 0, 0);
        send(8'h60); chk_cur("bs_at_origin", 0, 0);

        // LF, ignored bytes, printable range edges.
        send(8'h0A); chk_cur("lf", 1, 0);
        send(8'h01); chk_cur("other_01", 1, 0);
        expect_wr(A(1, 0), 8'h5E); send(8'h7E); chk_cur("tilde", 1, 1);
        expect_wr(A(1, 1), 8'h00); send(8'h20); chk_cur("space", 1, 2);
        send(8'h7F); chk_cur("other_7F", 1, 2);

        // Form feed from mid-screen.
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 40; c++)
                expect_wr(A(r, c), 8'h00);
        send(8'h0C);
        chk("ff_busy", {31'd0, busy}, 1);
        chk("ff_not_ready", {31'd0, char_ready}, 0);
        wait_idle(n);
        chk("clear_cycles", n, 640);
        chk_cur("after_clear", 0, 0);

        // Fill every visible cell; last one ('Z') triggers the scroll.
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 40; c++) begin
                if (r == 15 && c == 39) begin
                    chk_cur("before_Z", 15, 39);
                    expect_wr(A(15, 39), 8'h3A);
                    for (int sr = 0; sr < 15; sr++)
                        for (int sc = 0; sc < 40; sc++)
                            expect_wr(A(sr, sc), model[A(sr + 1, sc)]);
                    for (int sc = 0; sc < 40; sc++)
                        expect_wr(A(15, sc), 8'h00);
                    send(8'h5A);
                end else begin
                    b = 8'h21 + 8'((r * 3 + c) % 60);
                    expect_wr(A(r, c), b - 8'h20);
                    send(b);
                end
            end
        end
        chk("scroll_busy", {31'd0, busy}, 1);
        chk_cur("scroll_cursor", 15, 0);
        chk("nowrap_busy", {31'd0, busy2}, 0);
        chk("nowrap_cursor", {22'd0, cur_row2, cur_col2}, 0);
        wait_idle(n);
        chk("scroll_cycles", n, 1240);
        chk_cur("after_scroll", 15, 0);
        chk("ready_after_scroll", {31'd0, char_ready}, 1);
        @(posedge clk);
        #1;
        bad = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 40; c++)
                if (mem[A(r, c)] !== model[A(r, c)]) bad++;
        chk("screen_after_scroll", bad, 0);
        chk("row0_col0_from_row1", {24'd0, mem[A(0, 0)]}, 32'h04);
        chk("row14_col39_is_Z", {24'd0, mem[A(14, 39)]}, 32'h3A);
        chk("row15_cleared", {24'd0, mem[A(15, 5)]}, 32'h00);
        chk("nowrap_Z_written", {24'd0, mem2[A(15, 39)]}, 32'h3A);

        // Reset in the middle of a second scroll.
        sb_en = 1'b0;
        for (int i = 0; i < 40; i++) send(8'h51);
        chk("second_scroll_busy", {31'd0, busy}, 1);
        repeat (299) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midscroll_wr_en", {31'd0, wr_en}, 0);
        chk("midscroll_busy", {31'd0, busy}, 0);
        chk_cur("midscroll_cursor", 0, 0);
        chk("midscroll_wr_addr", {22'd0, wr_addr}, 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        chk("ready_after_midscroll", {31'd0, char_ready}, 1);
        chk("idle_after_midscroll", {31'd0, busy}, 0);
        exp_q.delete();
        sb_en = 1'b1;
        expect_wr(A(0, 0), 8'h21); send(8'h41); chk_cur("after_reset_A", 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
